alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 33 +++
 rtl/alu_sequencer_if.sv | 47 ++++
 rtl/alu_sequencer_settle_timer.sv | 29 ++
 rtl/alu_sequencer.sv | 103 ++++++++++
 tb/tb_alu_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared ALU defines: opcodes, settle default, sequencer types.
// Imported by the sequencer and by ALU control logic.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_XOR  = 3'd2,
    OP_SLT  = 3'd3,
    OP_AND  = 3'd4,
    OP_NAND = 3'd5,
    OP_NOR  = 3'd6,
    OP_OR   = 3'd7
  } alu_op_e;

  localparam int SETTLE_DEFAULT = 4;
  localparam int TIMER_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] result;
    logic        carryout;
    logic        zero;
    logic        overflow;
    logic [2:0]  command;
  } out_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request, ALU-side and result handshake bundle.
// slave is the sequencer view, master the environment view.
interface alu_sequencer_if #(
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      operandA;
  logic [31:0]      operandB;
  logic [2:0]       command;
  logic [31:0]      alu_operandA;
  logic [31:0]      alu_operandB;
  logic [2:0]       alu_command;
  logic [31:0]      alu_result;
  logic             alu_carryout;
  logic             alu_zero;
  logic             alu_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      result;
  logic             carryout;
  logic             zero;
  logic             overflow;
  logic [2:0]       result_command;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  in_valid, operandA, operandB, command,
    input  alu_result, alu_carryout, alu_zero,
    input  alu_overflow, out_ready,
    output in_ready, alu_operandA, alu_operandB,
    output alu_command, out_valid, result,
    output carryout, zero, overflow,
    output result_command, busy, op_count
  );

  modport master (
    output in_valid, operandA, operandB, command,
    output alu_result, alu_carryout, alu_zero,
    output alu_overflow, out_ready,
    input  in_ready, alu_operandA, alu_operandB,
    input  alu_command, out_valid, result,
    input  carryout, zero, overflow,
    input  result_command, busy, op_count
  );
endinterface

// File: rtl/alu_sequencer_settle_timer.sv
// Settle down-counter; done is registered so the ALU
// sees stable inputs for a full extra cycle before capture.
module settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);
  logic [W-1:0] count;
  logic         done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      done_q <= 1'b0;
    end else if (load) begin
      count  <= load_value;
      done_q <= 1'b0;
    end else begin
      done_q <= (count == '0);
      if (count != '0) count <= count - W'(1);
    end
  end

  assign done = done_q;
endmodule

// File: rtl/alu_sequencer.sv
// Sequences one request through an external ALU: latch,
// wait for settle, capture, hold until downstream takes it.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT,
  parameter int CNT_W         = 16
) (
  input logic            clk,
  input logic            reset,
  alu_sequencer_if.slave bus
);
  localparam logic [TIMER_W-1:0] LOAD_VAL =
    TIMER_W'(SETTLE_CYCLES - 1);

  state_e           state;
  state_e           state_nxt;
  logic             ready;
  logic             accept;
  logic             capture;
  logic             fire;
  logic             done;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [2:0]       cmd_q;
  out_t             out_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    capture   = 1'b0;
    fire      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) state_nxt = SETTLE;
      end
      SETTLE: begin
        capture = done;
        if (done) state_nxt = HOLD;
      end
      HOLD: begin
        ready = bus.out_ready;
        fire  = bus.out_ready;
        if (bus.out_ready)
          state_nxt = bus.in_valid ? SETTLE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = ready & bus.in_valid;

  settle_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_value(LOAD_VAL),
    .done      (done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      cmd_q <= '0;
      out_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q   <= bus.operandA;
        b_q   <= bus.operandB;
        cmd_q <= bus.command;
      end
      if (capture) begin
        out_q.result   <= bus.alu_result;
        out_q.carryout <= bus.alu_carryout;
        out_q.zero     <= bus.alu_zero;
        out_q.overflow <= bus.alu_overflow;
        out_q.command  <= cmd_q;
      end
      if (fire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready       = ready;
  assign bus.alu_operandA   = a_q;
  assign bus.alu_operandB   = b_q;
  assign bus.alu_command    = cmd_q;
  assign bus.out_valid      = (state == HOLD);
  assign bus.busy           = (state != IDLE);
  assign bus.result         = out_q.result;
  assign bus.carryout       = out_q.carryout;
  assign bus.zero           = out_q.zero;
  assign bus.overflow       = out_q.overflow;
  assign bus.result_command = out_q.command;
  assign bus.op_count       = cnt_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench: behavioural ALU, reference model, directed and
// randomized request sequences with immediate assertions.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int S  = 4;
  localparam int CW = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n_done;

  logic [31:0] cur_a;
  logic [31:0] cur_b;
  logic [2:0]  cur_c;
  logic [34:0] cur_e;

  alu_sequencer_if #(.CNT_W(CW)) bus ();

  alu_sequencer #(
    .SETTLE_CYCLES(S),
    .CNT_W        (CW)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {result, carryout, zero, overflow}
  function automatic logic [34:0] ref_alu(
    input logic [2:0]  c,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    logic [31:0] r;
    logic        co;
    logic        ov;
    co = 1'b0;
    ov = 1'b0;
    r  = '0;
    case (alu_op_e'(c))
      OP_ADD: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r  = s[31:0];
        co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_AND:  r = a & b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      default: r = a | b;
    endcase
    return {r, co, (r == 32'd0), ov};
  endfunction

  always_comb begin
    {bus.alu_result, bus.alu_carryout,
     bus.alu_zero, bus.alu_overflow} =
      ref_alu(bus.alu_command, bus.alu_operandA,
              bus.alu_operandB);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_cnt();
    chk("op_count", 32'(bus.op_count), 32'(n_done % 4));
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 1);
    chk({tag, "_result"}, bus.result, cur_e[34:3]);
    chk({tag, "_carry"}, 32'(bus.carryout), 32'(cur_e[2]));
    chk({tag, "_zero"}, 32'(bus.zero), 32'(cur_e[1]));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(cur_e[0]));
    chk({tag, "_cmd"}, 32'(bus.result_command), 32'(cur_c));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alu_a"}, bus.alu_operandA, 0);
    chk({tag, "_alu_b"}, bus.alu_operandB, 0);
    chk({tag, "_alu_cmd"}, 32'(bus.alu_command), 0);
    chk({tag, "_result"}, bus.result, 0);
    chk({tag, "_flags"},
        32'({bus.carryout, bus.zero, bus.overflow}), 0);
    chk({tag, "_rcmd"}, 32'(bus.result_command), 0);
    chk({tag, "_count"}, 32'(bus.op_count), 0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_ready"}, 32'(bus.in_ready), 1);
  endtask

  // Called at a negedge; the request is taken on the next edge.
  task automatic issue(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [2:0]  c);
    bus.in_valid = 1'b1;
    bus.operandA = a;
    bus.operandB = b;
    bus.command  = c;
    #1;
    chk("ready_pre", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    cur_a = a;
    cur_b = b;
    cur_c = c;
    cur_e = ref_alu(c, a, b);
    chk("acc_a", bus.alu_operandA, a);
    chk("acc_b", bus.alu_operandB, b);
    chk("acc_cmd", 32'(bus.alu_command), 32'(c));
    chk("acc_busy", 32'(bus.busy), 1);
    chk("acc_ready", 32'(bus.in_ready), 0);
    chk("acc_valid", 32'(bus.out_valid), 0);
    chk_cnt();
  endtask

  task automatic await_result();
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.operandA = $urandom;
      bus.operandB = $urandom;
      bus.command  = 3'($urandom);
      @(negedge clk);
      lat++;
      if (!bus.out_valid) begin
        chk("settle_a", bus.alu_operandA, cur_a);
        chk("settle_b", bus.alu_operandB, cur_b);
        chk("settle_rdy", 32'(bus.in_ready), 0);
      end
    end
    bus.in_valid = 1'b0;
    chk("latency", lat, S + 1);
    chk_out("cap");
    chk_cnt();
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_out("stall");
      chk("stall_rdy", 32'(bus.in_ready), 0);
      chk_cnt();
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    #1;
    chk("hold_rdy", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_done++;
    chk("drain_valid", 32'(bus.out_valid), 0);
    chk("drain_busy", 32'(bus.busy), 0);
    chk("drain_rdy", 32'(bus.in_ready), 1);
    chk_cnt();
  endtask

  task automatic b2b(input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [2:0]  c);
    bus.out_ready = 1'b1;
    n_done++;
    issue(a, b, c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total  = 0;
    bad    = 0;
    n_done = 0;
    rst    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.operandA  = '0;
    bus.operandB  = '0;
    bus.command   = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst = 1'b0;

    // out_ready while nothing is pending is ignored
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ordy_cnt", 32'(bus.op_count), 0);
    chk("idle_ordy_valid", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;

    // reset in SETTLE discards the operation
    issue(32'd9, 32'd3, OP_SUB);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;

    issue(32'd7, 32'd5, OP_ADD);
    await_result();
    chk("add_res", bus.result, 32'd12);
    chk("add_flags",
        32'({bus.carryout, bus.zero, bus.overflow}), 0);
    drain();

    issue(32'd5, 32'd5, OP_SUB);
    await_result();
    chk("sub_res", bus.result, 0);
    chk("sub_flags",
        32'({bus.carryout, bus.zero, bus.overflow}), 32'b110);
    drain();

    issue(32'h7FFF_FFFF, 32'd1, OP_ADD);
    await_result();
    chk("ovf_res", bus.result, 32'h8000_0000);
    chk("ovf_flag", 32'(bus.overflow), 1);
    drain();

    issue(32'hFFFF_FFFD, 32'd2, OP_SLT);
    await_result();
    chk("slt_res", bus.result, 32'd1);
    stall(10);
    b2b(32'hF0F0_1234, 32'h0FF0_FFFF, OP_AND);
    await_result();
    drain();

    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  c;
      a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9))
                                    : $urandom;
      b = $urandom_range(0, 3) == 0 ? a : $urandom;
      c = 3'($urandom);
      if (i != 0 && $urandom_range(0, 1) == 1) begin
        b2b(a, b, c);
      end else begin
        if (i != 0) drain();
        issue(a, b, c);
      end
      await_result();
      stall($urandom_range(0, 3));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
